pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque `WIDTH`-bit payload with a valid/ready handshake, an optional 2-entry skid buffer, flush, and sticky halt capture. It also keeps a saturating stall-cycle counter. Each stage instantiates it with its own packed payload struct from `cpu_types_pkg`.

## Interface
Parameters:
- `WIDTH`, 32: payload bits.
- `SKID`, 1: 1 selects the 2-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNTW`, 16: stall counter width.

Ports:
- `CLK`  in  1  clock. One clock domain; all state changes on the rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage can accept the payload.
- `in_data`  in  WIDTH  payload.
- `in_halt`  in  1  payload is a halt instruction.
- `flush`  in  1  discard all held entries.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  WIDTH  head payload.
- `out_halt`  out  1  halt bit of the head entry.
- `halted`  out  1  sticky: a halt entry has left the stage.
- `occupancy`  out  2  entries held (0–2).
- `stall_cnt`  out  CNTW  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Transfer in: `in_valid && in_ready`.
- Transfer out: `out_valid && out_ready`.
- Storage:
  - main register (head) plus skid register (only when `SKID=1`);
  - each entry holds data, a halt bit and a valid bit;
  - strict FIFO order; `out_data`/`out_halt` always come from main.
- State machine (`SKID=1`), EMPTY / ONE / TWO:
  - EMPTY + in → ONE, data to main.
  - ONE + in + out → ONE, main replaced.
  - ONE + in, no out → TWO, data to skid.
  - ONE + out, no in → EMPTY.
  - TWO + out → ONE, skid moves to main.
  - TWO + no out → TWO.
- `SKID=1` handshake:
  - `in_ready` is registered: 1 when the next state is not TWO, no halt entry is held or accepted, and `halted=0`.
- `SKID=0` mode:
  - EMPTY/ONE only;
  - `in_ready = (!out_valid || out_ready) && !halt_blocked && !RST`.
- Halt handling:
  - Once an entry with `in_halt=1` is accepted, no further input is accepted (`halt_blocked`).
  - When that entry transfers out, `halted` sets on the next edge and stays set until `RST`.
- Flush:
  - All entries invalid and state EMPTY on the next edge.
  - A same-cycle input transfer is dropped.
  - Flush clears `halt_blocked` when the halt entry had not yet left; it does not clear `halted`.
- Stall counter:
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNTW−1; it does not wrap.
  - Cleared only by `RST`.
- Reset values (`RST` high):
  - `out_valid`=0, `out_data`=0, `out_halt`=0;
  - `halted`=0, `occupancy`=0, `stall_cnt`=0, state EMPTY;
  - `in_ready`=0 while `RST` is high; `in_ready`=1 the first cycle after release.
- Priority: `RST` > `flush` > transfers.

## Timing
- Latency: an input transfer at edge N gives `out_valid`=1 after edge N.
- Throughput: one transfer per cycle sustained in both modes.
- `SKID=1`:
  - `in_ready` falls the cycle after reaching TWO;
  - it rises the cycle after leaving TWO;
  - no combinational path from `out_ready` to `in_ready`.
- `halted` asserts one cycle after the output transfer of the halt entry.
- `occupancy` and `stall_cnt` are registered and reflect state after the edge.
- `RST` mid-operation: everything returns to reset values at the next edge, whatever transfers are in flight.

## Structure
- `cpu_types_pkg` holds:
  - `pipe_state_t` enum (EMPTY, ONE, TWO);
  - the per-stage packed payload structs (`ifid_t`, `idex_t`, `exmem_t`, `memwb_t`) sized for `WIDTH`.
- Sub-module `sat_counter` (parameter `W`; inputs `inc`, `clr`): reused for `stall_cnt`.
- Existing stage interfaces are kept; the wrappers pack and unpack the structs around `pipe_stage_reg`.

## Test plan
- **Back-to-back throughput.** `SKID=1`, `out_ready`=1, stream 0x11, 0x22, 0x33 on consecutive cycles → outputs 0x11, 0x22, 0x33 one cycle later each; `occupancy` stays ≤1.
- **Skid fill and drain.** Hold `out_ready`=0, push 0xA0 then 0xB0 → `occupancy`=2, `in_ready`=0 next cycle, `stall_cnt` increments each cycle. Release `out_ready` → 0xA0 then 0xB0, `in_ready`=1 after the drain.
- **Flush with simultaneous input.** `occupancy`=2, assert `flush` while `in_valid`=1 with 0xCC → next cycle `out_valid`=0, `occupancy`=0, 0xCC never appears.
- **Halt capture.** Push 0x10 (halt=1) then 0x20 → 0x20 is not accepted; `halted`=1 one cycle after 0x10 transfers out; `flush` leaves `halted`=1; only `RST` clears it.
- **Counter saturation.** `CNTW=4`, stall 20 cycles → `stall_cnt`=15 and holds.
- **Reset mid-stream.** `SKID=0`, assert `RST` with an entry held and `in_valid`=1 → all outputs zero, `in_ready`=0 during reset, `in_ready`=1 the first cycle after.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: elastic-stage occupancy states and the packed per-stage payloads
// carried through pipe_stage_reg.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned STAGE_WIDTH = 32;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [11:0] rs1_val;
    logic [11:0] imm;
  } idex_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        wb_en;
    logic [15:0] alu_result;
    logic [8:0]  store_data;
  } exmem_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic        wb_en;
    logic [26:0] wb_data;
  } memwb_t;

  function automatic logic [1:0] occ_of(pipe_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one elastic pipeline stage; master is upstream/downstream, slave is the stage.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_halt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_halt;
  logic             halted;
  logic [1:0]       occupancy;
  logic [CNTW-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, in_halt, flush, out_ready,
    input  in_ready, out_valid, out_data, out_halt, halted, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_halt, flush, out_ready,
    output in_ready, out_valid, out_data, out_halt, halted, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline-stage register: valid/ready payload with optional 2-entry skid,
// flush, sticky halt capture and a saturating stall counter.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNTW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  pipe_stage_reg_if.slave   bus
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic             main_halt_q, main_halt_d, skid_halt_q, skid_halt_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             halt_blocked_q, halt_blocked_d;
  logic             halted_q, halted_d;
  logic             in_ready;
  logic             in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = main_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_halt  = main_halt_q;
  assign bus.halted    = halted_q;
  assign bus.occupancy = occ_of(state_q);

  // Skid mode registers ready from the next state, so out_ready never reaches in_ready.
  if (SKID != 0) begin : g_skid
    logic rdy_q;
    always_ff @(posedge CLK) begin
      if (RST) rdy_q <= 1'b1;
      else     rdy_q <= (state_d != TWO) && !halt_blocked_d && !halted_d;
    end
    assign in_ready = rdy_q && !RST;
  end else begin : g_single
    assign in_ready = (!main_valid_q || bus.out_ready) && !halt_blocked_q && !RST;
  end

  always_comb begin
    state_d        = state_q;
    main_data_d    = main_data_q;
    main_halt_d    = main_halt_q;
    main_valid_d   = main_valid_q;
    skid_data_d    = skid_data_q;
    skid_halt_d    = skid_halt_q;
    skid_valid_d   = skid_valid_q;
    halt_blocked_d = halt_blocked_q;
    halted_d       = halted_q;

    if (out_xfer && main_halt_q) halted_d = 1'b1;
    if (in_xfer && bus.in_halt)  halt_blocked_d = 1'b1;

    if (bus.flush) begin
      state_d      = EMPTY;
      main_valid_d = 1'b0;
      main_halt_d  = 1'b0;
      skid_valid_d = 1'b0;
      skid_halt_d  = 1'b0;
      // The block is lifted only if the halt entry is discarded rather than already delivered.
      if (!halted_d) halt_blocked_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d      = ONE;
            main_data_d  = bus.in_data;
            main_halt_d  = bus.in_halt;
            main_valid_d = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_d = bus.in_data;
            main_halt_d = bus.in_halt;
          end else if (in_xfer) begin
            state_d      = TWO;
            skid_data_d  = bus.in_data;
            skid_halt_d  = bus.in_halt;
            skid_valid_d = 1'b1;
          end else if (out_xfer) begin
            state_d      = EMPTY;
            main_valid_d = 1'b0;
            main_halt_d  = 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d      = ONE;
            main_data_d  = skid_data_q;
            main_halt_d  = skid_halt_q;
            skid_valid_d = 1'b0;
            skid_halt_d  = 1'b0;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= EMPTY;
      main_data_q    <= '0;
      main_halt_q    <= 1'b0;
      main_valid_q   <= 1'b0;
      skid_data_q    <= '0;
      skid_halt_q    <= 1'b0;
      skid_valid_q   <= 1'b0;
      halt_blocked_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      main_data_q    <= main_data_d;
      main_halt_q    <= main_halt_d;
      main_valid_q   <= main_valid_d;
      skid_data_q    <= skid_data_d;
      skid_halt_q    <= skid_halt_d;
      skid_valid_q   <= skid_valid_d;
      halt_blocked_q <= halt_blocked_d;
      halted_q       <= halted_d;
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (main_valid_q && !bus.out_ready),
    .count (bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid stage, 4-bit-counter skid stage and single-entry stage.
module tb_pipe_stage_reg;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vec = 0;
  int   errs = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg_if #(.WIDTH(8), .CNTW(16)) bus_a ();
  pipe_stage_reg_if #(.WIDTH(8), .CNTW(4))  bus_s ();
  pipe_stage_reg_if #(.WIDTH(8), .CNTW(16)) bus_z ();

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CNTW(16)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CNTW(4))  dut_s (.CLK(CLK), .RST(RST), .bus(bus_s));
  pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNTW(16)) dut_z (.CLK(CLK), .RST(RST), .bus(bus_z));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); end
    vec++; if (bus_a.out_data !== 8'h00) begin errs++; $display("FAIL rst_out_data: got %h want 00", bus_a.out_data); end
    vec++; if (bus_a.occupancy !== 2'd0) begin errs++; $display("FAIL rst_occ: got %0d want 0", bus_a.occupancy); end
    vec++; if (bus_a.stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall: got %0d want 0", bus_a.stall_cnt); end
    vec++; if (bus_a.halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b want 0", bus_a.halted); end
    vec++; if (bus_a.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", bus_a.in_ready); end
    RST = 1'b0;
    #1;
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready_skid: got %b want 1", bus_a.in_ready); end
    vec++; if (bus_z.in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready_single: got %b want 1", bus_z.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = vals[i];
      step();
      vec++; if (bus_a.out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus_a.out_valid); end
      vec++; if (bus_a.out_data !== vals[i]) begin errs++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus_a.out_data, vals[i]); end
      vec++; if (bus_a.occupancy !== 2'd1) begin errs++; $display("FAIL b2b_occ[%0d]: got %0d want 1", i, bus_a.occupancy); end
      vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus_a.in_ready); end
    end
    bus_a.in_valid = 1'b0;
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain_valid: got %b want 0", bus_a.out_valid); end
    vec++; if (bus_a.occupancy !== 2'd0) begin errs++; $display("FAIL b2b_drain_occ: got %0d want 0", bus_a.occupancy); end
  endtask

  task automatic test_skid_fill_drain();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'hA0;
    step();
    vec++; if (bus_a.occupancy !== 2'd1) begin errs++; $display("FAIL fill_occ1: got %0d want 1", bus_a.occupancy); end
    vec++; if (bus_a.stall_cnt !== 16'd0) begin errs++; $display("FAIL fill_stall0: got %0d want 0", bus_a.stall_cnt); end
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL fill_in_ready1: got %b want 1", bus_a.in_ready); end
    bus_a.in_data = 8'hB0;
    step();
    bus_a.in_valid = 1'b0;
    vec++; if (bus_a.occupancy !== 2'd2) begin errs++; $display("FAIL fill_occ2: got %0d want 2", bus_a.occupancy); end
    vec++; if (bus_a.in_ready !== 1'b0) begin errs++; $display("FAIL fill_in_ready_full: got %b want 0", bus_a.in_ready); end
    vec++; if (bus_a.stall_cnt !== 16'd1) begin errs++; $display("FAIL fill_stall1: got %0d want 1", bus_a.stall_cnt); end
    for (int i = 2; i <= 3; i++) begin
      step();
      vec++; if (bus_a.stall_cnt !== 16'(i)) begin errs++; $display("FAIL fill_stall_inc: got %0d want %0d", bus_a.stall_cnt, i); end
      vec++; if (bus_a.out_data !== 8'hA0) begin errs++; $display("FAIL fill_head_hold: got %h want a0", bus_a.out_data); end
    end
    bus_a.out_ready = 1'b1;
    step();
    vec++; if (bus_a.out_data !== 8'hB0) begin errs++; $display("FAIL drain_second: got %h want b0", bus_a.out_data); end
    vec++; if (bus_a.occupancy !== 2'd1) begin errs++; $display("FAIL drain_occ1: got %0d want 1", bus_a.occupancy); end
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL drain_in_ready: got %b want 1", bus_a.in_ready); end
    vec++; if (bus_a.stall_cnt !== 16'd3) begin errs++; $display("FAIL drain_stall_hold: got %0d want 3", bus_a.stall_cnt); end
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty: got %b want 0", bus_a.out_valid); end
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL drain_in_ready_empty: got %b want 1", bus_a.in_ready); end
  endtask

  task automatic test_flush();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'h01;
    step();
    bus_a.in_data   = 8'h02;
    step();
    vec++; if (bus_a.occupancy !== 2'd2) begin errs++; $display("FAIL flush_pre_occ: got %0d want 2", bus_a.occupancy); end
    bus_a.in_data = 8'hCC;
    bus_a.flush   = 1'b1;
    step();
    bus_a.flush    = 1'b0;
    bus_a.in_valid = 1'b0;
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL flush_full_valid: got %b want 0", bus_a.out_valid); end
    vec++; if (bus_a.occupancy !== 2'd0) begin errs++; $display("FAIL flush_full_occ: got %0d want 0", bus_a.occupancy); end
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL flush_full_in_ready: got %b want 1", bus_a.in_ready); end
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL flush_full_no_cc: got %b want 0", bus_a.out_valid); end
    // one entry held, in_ready high: the simultaneous transfer itself must be dropped
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h05;
    step();
    vec++; if (bus_a.out_data !== 8'h05) begin errs++; $display("FAIL flush_one_pre: got %h want 05", bus_a.out_data); end
    bus_a.in_data = 8'hCC;
    bus_a.flush   = 1'b1;
    step();
    bus_a.flush    = 1'b0;
    bus_a.in_valid = 1'b0;
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL flush_one_valid: got %b want 0", bus_a.out_valid); end
    vec++; if (bus_a.occupancy !== 2'd0) begin errs++; $display("FAIL flush_one_occ: got %0d want 0", bus_a.occupancy); end
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL flush_one_no_cc: got %b want 0", bus_a.out_valid); end
  endtask

  task automatic test_halt();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'h10;
    bus_a.in_halt   = 1'b1;
    step();
    vec++; if (bus_a.out_halt !== 1'b1) begin errs++; $display("FAIL halt_head_bit: got %b want 1", bus_a.out_halt); end
    vec++; if (bus_a.in_ready !== 1'b0) begin errs++; $display("FAIL halt_blocked_ready: got %b want 0", bus_a.in_ready); end
    bus_a.in_data = 8'h20;
    bus_a.in_halt = 1'b0;
    step();
    vec++; if (bus_a.occupancy !== 2'd1) begin errs++; $display("FAIL halt_reject_occ: got %0d want 1", bus_a.occupancy); end
    vec++; if (bus_a.out_data !== 8'h10) begin errs++; $display("FAIL halt_reject_head: got %h want 10", bus_a.out_data); end
    vec++; if (bus_a.halted !== 1'b0) begin errs++; $display("FAIL halt_early: got %b want 0", bus_a.halted); end
    bus_a.out_ready = 1'b1;
    step();
    vec++; if (bus_a.halted !== 1'b1) begin errs++; $display("FAIL halt_set: got %b want 1", bus_a.halted); end
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL halt_no_0x20: got %b want 0", bus_a.out_valid); end
    bus_a.flush = 1'b1;
    step();
    bus_a.flush = 1'b0;
    vec++; if (bus_a.halted !== 1'b1) begin errs++; $display("FAIL halt_survives_flush: got %b want 1", bus_a.halted); end
    vec++; if (bus_a.in_ready !== 1'b0) begin errs++; $display("FAIL halt_ready_after_flush: got %b want 0", bus_a.in_ready); end
    step();
    vec++; if (bus_a.out_valid !== 1'b0) begin errs++; $display("FAIL halt_still_blocked: got %b want 0", bus_a.out_valid); end
    bus_a.in_valid = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    vec++; if (bus_a.halted !== 1'b0) begin errs++; $display("FAIL halt_rst_clear: got %b want 0", bus_a.halted); end
    #1;
    vec++; if (bus_a.in_ready !== 1'b1) begin errs++; $display("FAIL halt_rst_ready: got %b want 1", bus_a.in_ready); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    bus_s.out_ready = 1'b0;
    bus_s.in_valid  = 1'b1;
    bus_s.in_data   = 8'h5A;
    step();
    bus_s.in_valid = 1'b0;
    vec++; if (bus_s.stall_cnt !== 4'd0) begin errs++; $display("FAIL sat_start: got %0d want 0", bus_s.stall_cnt); end
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = (i < 15) ? 4'(i) : 4'd15;
      vec++; if (bus_s.stall_cnt !== exp) begin errs++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus_s.stall_cnt, exp); end
    end
    bus_s.out_ready = 1'b1;
    step();
    vec++; if (bus_s.stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_hold: got %0d want 15", bus_s.stall_cnt); end
  endtask

  task automatic test_reset_midstream();
    bus_z.out_ready = 1'b0;
    bus_z.in_valid  = 1'b1;
    bus_z.in_data   = 8'h77;
    #1;
    vec++; if (bus_z.in_ready !== 1'b1) begin errs++; $display("FAIL z_ready_empty: got %b want 1", bus_z.in_ready); end
    step();
    bus_z.in_valid = 1'b0;
    step();
    vec++; if (bus_z.out_data !== 8'h77) begin errs++; $display("FAIL z_head: got %h want 77", bus_z.out_data); end
    vec++; if (bus_z.stall_cnt !== 16'd1) begin errs++; $display("FAIL z_stall: got %0d want 1", bus_z.stall_cnt); end
    bus_z.in_valid = 1'b1;
    bus_z.in_data  = 8'h88;
    #1;
    vec++; if (bus_z.in_ready !== 1'b0) begin errs++; $display("FAIL z_ready_full: got %b want 0", bus_z.in_ready); end
    bus_z.out_ready = 1'b1;
    #1;
    vec++; if (bus_z.in_ready !== 1'b1) begin errs++; $display("FAIL z_ready_pass: got %b want 1", bus_z.in_ready); end
    RST = 1'b1;
    #1;
    vec++; if (bus_z.in_ready !== 1'b0) begin errs++; $display("FAIL z_ready_in_rst: got %b want 0", bus_z.in_ready); end
    step();
    vec++; if (bus_z.out_valid !== 1'b0) begin errs++; $display("FAIL z_rst_valid: got %b want 0", bus_z.out_valid); end
    vec++; if (bus_z.out_data !== 8'h00) begin errs++; $display("FAIL z_rst_data: got %h want 00", bus_z.out_data); end
    vec++; if (bus_z.occupancy !== 2'd0) begin errs++; $display("FAIL z_rst_occ: got %0d want 0", bus_z.occupancy); end
    vec++; if (bus_z.stall_cnt !== 16'd0) begin errs++; $display("FAIL z_rst_stall: got %0d want 0", bus_z.stall_cnt); end
    vec++; if (bus_z.in_ready !== 1'b0) begin errs++; $display("FAIL z_rst_ready: got %b want 0", bus_z.in_ready); end
    RST = 1'b0;
    bus_z.in_valid = 1'b0;
    #1;
    vec++; if (bus_z.in_ready !== 1'b1) begin errs++; $display("FAIL z_rel_ready: got %b want 1", bus_z.in_ready); end
    step();
    vec++; if (bus_z.out_valid !== 1'b0) begin errs++; $display("FAIL z_post_valid: got %b want 0", bus_z.out_valid); end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_halt = 1'b0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_halt = 1'b0; bus_s.flush = 1'b0; bus_s.out_ready = 1'b0;
    bus_z.in_valid = 1'b0; bus_z.in_data = '0; bus_z.in_halt = 1'b0; bus_z.flush = 1'b0; bus_z.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_skid_fill_drain();
    test_flush();
    test_halt();
    test_saturation();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
